reorder_buffer: RTL and testbench

In-order reorder buffer for the out-of-order core; sits directly downstream of dispatch. Allocates one entry per dispatched instruction and returns the entry index plus a full flag to dispatch. Marks entries complete from the writeback bus and retires them in program order, at most one per cycle, to the architectural register file. A flush input discards all in-flight entries.

---
 rtl/reorder_buffer.sv | 116 +++++++++++
 tb/tb_reorder_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer between dispatch and the architectural register file.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   fire_valid, dest_reg,     dispatch allocation request, destination and
//   wb_en                     register-write flag of the dispatching instruction
//   rob_entry_idx, rob_full   entry index handed to dispatch (tail) and full flag
//   cdb_valid, cdb_rob_idx,   writeback-bus result marking an entry complete
//   cdb_data
//   commit_valid,             head entry retiring this cycle with its destination,
//   commit_dest_reg,          result and register file write enable
//   commit_data, commit_wb_en
//   flush                     discard all in-flight entries
//   rob_count                 number of occupied entries
module reorder_buffer #(
    parameter int ROB_ENTRIES = 16,
    localparam int IDX_W = $clog2(ROB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_valid,
    input  logic [4:0]       dest_reg,
    input  logic             wb_en,
    output logic [IDX_W-1:0] rob_entry_idx,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_rob_idx,
    input  logic [31:0]      cdb_data,
    output logic             commit_valid,
    output logic [4:0]       commit_dest_reg,
    output logic [31:0]      commit_data,
    output logic             commit_wb_en,
    input  logic             flush,
    output logic [IDX_W:0]   rob_count
);
    logic [ROB_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, wbe_q, wbe_d;
    logic [4:0]             dest_q [ROB_ENTRIES];
    logic [4:0]             dest_d [ROB_ENTRIES];
    logic [31:0]            data_q [ROB_ENTRIES];
    logic [31:0]            data_d [ROB_ENTRIES];
    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]         count_q, count_d;
    logic                   alloc, retire;

    // Full and index come from registered state only, so dispatch sees no
    // combinational path from its own fire or from the writeback bus.
    assign rob_full        = count_q == (IDX_W+1)'(ROB_ENTRIES);
    assign rob_entry_idx   = tail_q;
    assign rob_count       = count_q;
    assign alloc           = fire_valid && !rob_full;
    assign retire          = valid_q[head_q] && done_q[head_q];
    assign commit_valid    = retire;
    assign commit_dest_reg = retire ? dest_q[head_q] : '0;
    assign commit_data     = retire ? data_q[head_q] : '0;
    // Writes to x0 are architecturally discarded.
    assign commit_wb_en    = retire && wbe_q[head_q] && dest_q[head_q] != 5'd0;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        wbe_d   = wbe_q;
        dest_d  = dest_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (IDX_W+1)'(alloc) - (IDX_W+1)'(retire);
        if (cdb_valid && valid_q[cdb_rob_idx]) begin
            done_d[cdb_rob_idx] = 1'b1;
            data_d[cdb_rob_idx] = cdb_data;
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_W'(1);
        end
        // Tail can only alias head when empty (no retire) or full (no alloc),
        // so allocation never collides with completion or retirement.
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            wbe_d[tail_q]   = wb_en;
            dest_d[tail_q]  = dest_reg;
            data_d[tail_q]  = '0;
            tail_d          = tail_q + IDX_W'(1);
        end
        // Flush wins over everything; a retirement shown this cycle still stands.
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            wbe_q   <= '0;
            dest_q  <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            wbe_q   <= wbe_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random stimulus against a queue-based program-order model.
module tb_reorder_buffer;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fire_valid = 1'b0;
    logic [4:0]  dest_reg = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  rob_entry_idx;
    logic        rob_full;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_rob_idx = '0;
    logic [31:0] cdb_data = '0;
    logic        commit_valid;
    logic [4:0]  commit_dest_reg;
    logic [31:0] commit_data;
    logic        commit_wb_en;
    logic        flush = 1'b0;
    logic [4:0]  rob_count;

    reorder_buffer #(.ROB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst),
        .fire_valid(fire_valid), .dest_reg(dest_reg), .wb_en(wb_en),
        .rob_entry_idx(rob_entry_idx), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_dest_reg(commit_dest_reg),
        .commit_data(commit_data), .commit_wb_en(commit_wb_en),
        .flush(flush), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [4:0]  dest;
        logic        wbe;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   tail = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input logic fv, input logic [4:0] d, input logic we,
                        input logic cv, input logic [3:0] ci, input logic [31:0] cd,
                        input logic fl);
        logic ecv;
        int   n;
        @(negedge clk);
        n   = q.size();
        ecv = n > 0 && q[0].done;
        check("count", rob_count, n);
        check("full", rob_full, n == N);
        check("idx", rob_entry_idx, tail);
        check("commit_valid", commit_valid, ecv);
        check("commit_dest", commit_dest_reg, ecv ? q[0].dest : 5'd0);
        check("commit_data", commit_data, ecv ? q[0].data : 32'd0);
        check("commit_wb_en", commit_wb_en, ecv && q[0].wbe && q[0].dest != 5'd0);
        fire_valid = fv; dest_reg = d; wb_en = we;
        cdb_valid = cv; cdb_rob_idx = ci; cdb_data = cd; flush = fl;
        if (fl) begin
            q.delete();
            tail = 0;
        end else begin
            if (cv)
                for (int i = 0; i < q.size(); i++)
                    if (q[i].idx == int'(ci)) begin
                        q[i].done = 1'b1;
                        q[i].data = cd;
                    end
            if (ecv) void'(q.pop_front());
            if (fv && n < N) begin
                q.push_back('{tail, d, we, 1'b0, 32'd0});
                tail = (tail + 1) % N;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fire(input logic [4:0] d, input logic we);
        step(1, d, we, 0, 0, 0, 0);
    endtask

    task automatic cdb(input logic [3:0] ci, input logic [31:0] cd);
        step(0, 0, 0, 1, ci, cd, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() > 0; k++)
            cdb(4'(q[$urandom_range(q.size() - 1, 0)].idx), $urandom);
        for (int k = 0; k < 4; k++) idle();
        check("drained", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_idx", rob_entry_idx, 0);
        check("rst_full", rob_full, 0);
        check("rst_count", rob_count, 0);
        check("rst_cv", commit_valid, 0);
        rst = 1'b0;
        // Three fires, completion in reverse order, in-order retirement.
        fire(1, 1); fire(2, 1); fire(3, 1);
        idle(); idle();
        cdb(2, 32'h30); cdb(1, 32'h20); cdb(0, 32'h10);
        repeat (5) idle();
        // Fill, overflow attempt, retire head, refill with wrapped index.
        for (int k = 0; k < N; k++) fire(5'($urandom_range(31, 1)), 1);
        fire(7, 1);
        idle();
        cdb(4'(q[0].idx), 32'hABCD);
        fire(9, 1);
        idle(); idle();
        fire(10, 1);
        drain();
        // x0 destination and wb_en=0 never write the register file.
        fire(0, 1); fire(5, 0);
        cdb(4'(q[0].idx), 32'h55); cdb(4'(q[1].idx), 32'h66);
        repeat (3) idle();
        // Flush with five in flight, two done, and concurrent fire/cdb.
        for (int k = 0; k < 5; k++) fire(5'(k + 1), 1);
        cdb(4'(q[1].idx), 32'h11); cdb(4'(q[3].idx), 32'h33);
        step(1, 12, 1, 1, 4'(q[2].idx), 32'h22, 1);
        cdb(3, 32'h77);
        repeat (3) idle();
        // Back-to-back fire with completion of the newest entry, wrapping indices.
        fire(1, 1);
        for (int k = 0; k < 20; k++) step(1, 5'(k + 1), 1, 1, 4'(q[q.size() - 1].idx), $urandom, 0);
        drain();
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] ci;
            ci = (q.size() > 0 && $urandom_range(3, 0) != 0) ? 4'(q[$urandom_range(q.size() - 1, 0)].idx)
                                                            : 4'($urandom_range(N - 1, 0));
            step($urandom_range(9, 0) < 6, 5'($urandom), 1'($urandom), $urandom_range(9, 0) < 6,
                 ci, $urandom, $urandom_range(99, 0) < 2);
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
